// File: rtl/demux_1_4_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1_4_stream
// Brief    : 1-to-4 stream demultiplexer with an independent FIFO and
//            delivered-word counter per output channel.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1_4_stream #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,
    output logic [7:0]       cnt3
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] head_w [4];
    logic [7:0]       cnt_w  [4];
    logic [3:0]       full_w;

    // Readiness looks only at the addressed queue, so a stalled channel
    // never blocks words bound elsewhere.
    assign d_ready = !rst && !full_w[sel];

    for (genvar gi = 0; gi < 4; gi++) begin : g_q
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0]    occ_q, occ_d;
        logic [7:0]       cnt_q, cnt_d;
        logic             push_w, pop_w;

        assign push_w = d_valid && d_ready && (sel == 2'(gi));
        assign pop_w  = (occ_q != '0) && y_ready[gi];

        always_comb begin
            wr_d  = wr_q;
            rd_d  = rd_q;
            occ_d = occ_q;
            cnt_d = cnt_q;
            if (push_w) begin
                wr_d = wr_q + PW'(1);
            end
            if (pop_w) begin
                rd_d  = rd_q + PW'(1);
                cnt_d = cnt_q + 8'd1;
            end
            if (push_w && !pop_w) begin
                occ_d = occ_q + CW'(1);
            end else if (pop_w && !push_w) begin
                occ_d = occ_q - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_q  <= '0;
                rd_q  <= '0;
                occ_q <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                occ_q <= occ_d;
                cnt_q <= cnt_d;
            end
        end

        // Storage needs no reset: push_w is held low during reset and the
        // head is masked to zero whenever the queue is empty.
        always_ff @(posedge clk) begin
            if (push_w) begin
                mem_q[wr_q] <= d;
            end
        end

        assign full_w[gi]  = (occ_q == CW'(DEPTH));
        assign y_valid[gi] = (occ_q != '0);
        assign head_w[gi]  = (occ_q != '0) ? mem_q[rd_q] : '0;
        assign cnt_w[gi]   = cnt_q;
    end

    assign y0   = head_w[0];
    assign y1   = head_w[1];
    assign y2   = head_w[2];
    assign y3   = head_w[3];
    assign cnt0 = cnt_w[0];
    assign cnt1 = cnt_w[1];
    assign cnt2 = cnt_w[2];
    assign cnt3 = cnt_w[3];

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1_4_stream
// Brief    : Self-checking bench for demux_1_4_stream against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1_4_stream;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic [1:0]       sel;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic [3:0]       y_valid;
    logic [3:0]       y_ready;
    logic [7:0]       cnt0, cnt1, cnt2, cnt3;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mq [4][$];
    int               mcnt [4];

    always #5 clk = ~clk;

    demux_1_4_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .sel     (sel),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .y0      (y0),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .cnt0    (cnt0),
        .cnt1    (cnt1),
        .cnt2    (cnt2),
        .cnt3    (cnt3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [WIDTH-1:0] yv [4];
        logic [7:0]       cv [4];
        yv = '{y0, y1, y2, y3};
        cv = '{cnt0, cnt1, cnt2, cnt3};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("y_valid[%0d]", i), 32'(y_valid[i]), 32'(mq[i].size() != 0));
            check($sformatf("y%0d", i), 32'(yv[i]),
                  (mq[i].size() != 0) ? 32'(mq[i][0]) : 32'd0);
            check($sformatf("cnt%0d", i), 32'(cv[i]), 32'(mcnt[i]));
        end
    endtask

    // Drive one cycle of inputs, check d_ready, advance the model on the
    // edge, then check all outputs half a cycle later.
    task automatic step(input logic r, input logic [WIDTH-1:0] dv, input logic [1:0] s,
                        input logic v, input logic [3:0] yr);
        int  pre [4];
        bit  acc;
        rst = r; d = dv; sel = s; d_valid = v; y_ready = yr;
        #1;
        acc = !r && (mq[s].size() < DEPTH);
        check("d_ready", 32'(d_ready), 32'(acc));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                mcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) pre[i] = mq[i].size();
            for (int i = 0; i < 4; i++) begin
                if (pre[i] != 0 && yr[i]) begin
                    void'(mq[i].pop_front());
                    mcnt[i] = (mcnt[i] + 1) % 256;
                end
            end
            if (v && acc) mq[s].push_back(dv);
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; d = '0; sel = '0; d_valid = 1'b0; y_ready = '0;
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        @(negedge clk);

        // Reset and basic routing with one-cycle latency
        step(1, 0, 0, 0, 4'h0);
        step(1, 0, 0, 0, 4'h0);
        step(0, 4'hA, 2'd2, 1, 4'hF);
        check("route_yv", 32'(y_valid), 32'(4'b0100));
        check("route_y2", 32'(y2), 32'hA);
        step(0, 4'h0, 2'd0, 0, 4'hF);
        check("route_cnt2", 32'(cnt2), 32'd1);

        // Full queue holds the third word, no bypass even while popping
        step(0, 4'h1, 2'd1, 1, 4'h0);
        step(0, 4'h2, 2'd1, 1, 4'h0);
        step(0, 4'h3, 2'd1, 1, 4'h0);
        check("full_y1", 32'(y1), 32'h1);
        step(0, 4'h3, 2'd1, 1, 4'b0010);
        check("nobypass_y1", 32'(y1), 32'h2);
        step(0, 4'h3, 2'd1, 1, 4'b0010);
        check("order_y1", 32'(y1), 32'h3);
        step(0, 4'h0, 2'd0, 0, 4'b0010);

        // Stalled queue 3 must not block queue 0
        step(0, 4'h7, 2'd3, 1, 4'h0);
        step(0, 4'h8, 2'd3, 1, 4'h0);
        step(0, 4'h9, 2'd0, 1, 4'h0);
        check("indep_y0", 32'(y0), 32'h9);

        // Simultaneous push and pop on queue 0
        step(0, 4'h5, 2'd0, 1, 4'b0001);
        check("pushpop_yv0", 32'(y_valid[0]), 32'd1);
        check("pushpop_occ", 32'(mq[0].size()), 32'd1);
        check("pushpop_y0", 32'(y0), 32'h5);

        // Counter wrap on channel 3
        step(1, 0, 0, 0, 4'h0);
        for (int k = 0; k < 257; k++) begin
            step(0, WIDTH'($urandom), 2'd3, 1, 4'b1000);
        end
        check("wrap_cnt3", 32'(cnt3), 32'd0);
        step(0, 0, 0, 0, 4'b1000);
        check("wrap_cnt3_next", 32'(cnt3), 32'd1);

        // Reset while queues are partly full
        for (int k = 0; k < 6; k++) begin
            step(0, WIDTH'($urandom), 2'(k % 4), 1, 4'h0);
        end
        step(1, 4'hF, 2'd0, 1, 4'hF);
        check("rst_yv", 32'(y_valid), 32'd0);
        check("rst_y", 32'({y0, y1, y2, y3}), 32'd0);
        check("rst_cnt", 32'({cnt0, cnt1, cnt2, cnt3}), 32'd0);
        step(0, 4'h6, 2'd1, 1, 4'h0);
        check("post_rst_y1", 32'(y1), 32'h6);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 59) == 0), WIDTH'($urandom), 2'($urandom),
                 1'($urandom), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 Parameter WIDTH, default 4: data width of the input word and of every output word.
REQ-002 Parameter DEPTH, default 2: entries per output queue; legal values are 2 and 4.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port d, input, WIDTH: input data word.
REQ-006 Port sel, input, 2: destination index 0..3 of the current input word.
REQ-007 Port d_valid, input, 1: the input word is offered.
REQ-008 Port d_ready, output, 1: the block can accept the input word this cycle.
REQ-009 Ports y0, y1, y2, y3, output, WIDTH each: head word of output queue 0..3.
REQ-010 Port y_valid, output, 4: bit i means yi holds a valid word.
REQ-011 Port y_ready, input, 4: bit i means the consumer takes yi this cycle.
REQ-012 Ports cnt0, cnt1, cnt2, cnt3, output, 8 each: count of words delivered on output 0..3.

Function
REQ-013 An input transfer SHALL occur exactly on a rising edge where d_valid and d_ready are both 1.
REQ-014 A transferred word SHALL be written into queue[sel]; sel is sampled on the same edge as d.
REQ-015 d_ready SHALL equal "queue[sel] not full" and SHALL be 0 while rst is 1.
REQ-016 d_ready SHALL depend combinationally on sel only; it SHALL NOT depend on d_valid or on y_ready.
REQ-017 A word in a full queue SHALL NOT be accepted, even if that queue pops on the same edge (no full-queue bypass).
REQ-018 An output transfer on channel i SHALL occur on a rising edge where y_valid[i] and y_ready[i] are both 1; it removes the head of queue i.
REQ-019 Latency SHALL be one cycle: a word accepted into an empty queue i at edge N appears on yi with y_valid[i]=1 immediately after edge N.
REQ-020 y_valid[i] SHALL be 1 exactly when queue i is non-empty.
REQ-021 yi SHALL be driven from a register or a queue entry, never combinationally from d.
REQ-022 yi SHALL be all-zero while queue i is empty.
REQ-023 Each queue SHALL preserve FIFO order; words are never lost, duplicated or routed to another index.
REQ-024 A push and a pop on the same non-full, non-empty queue on one edge SHALL leave its occupancy unchanged.
REQ-025 A push to an empty queue SHALL make the word visible on the next cycle; there is no combinational pass-through.
REQ-026 The four queues SHALL operate independently; a stalled output SHALL NOT block input words addressed to other indices.
REQ-027 Queue pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked so that full and empty are unambiguous.
REQ-028 cnti SHALL increment by 1 on every output transfer on channel i and SHALL wrap from 255 to 0.
REQ-029 d, sel and y_ready SHALL be ignored when the corresponding valid is 0, and y_ready[i] SHALL be ignored when y_valid[i] is 0.

Reset
REQ-030 While rst is 1 at an edge, all queues SHALL empty, y_valid SHALL be 4'b0000, y0..y3 SHALL be 0 and cnt0..cnt3 SHALL be 0.
REQ-031 A reset asserted mid-operation SHALL discard all queued words with no output transfer and no counter increment on that edge.
REQ-032 On the first edge after rst deasserts, the block SHALL accept input normally.

Verification
REQ-033 Scenario: reset, then d=4'hA, sel=2, d_valid=1 for one cycle, y_ready=4'hF -> next cycle y_valid=4'b0100, y2=4'hA, y0=y1=y3=0; one cycle later cnt2=1.
REQ-034 Scenario: y_ready=0, push 3'rd word to sel=1 with DEPTH=2 -> d_ready=0 after two accepts; the third word is held; y1 shows the 1st word; after y_ready[1]=1 the words arrive in order.
REQ-035 Scenario: queue 3 full and stalled, d_valid=1 with sel=0 -> d_ready=1 and the word appears on y0 next cycle.
REQ-036 Scenario: queue 0 holds 1 entry, push and pop on queue 0 on the same edge -> y_valid[0] stays 1 and occupancy stays 1.
REQ-037 Scenario: 256 transfers on channel 3 -> cnt3 steps 0..255 then reads 0.
REQ-038 Scenario: rst=1 while all queues are partly full -> next cycle y_valid=0, y0..y3=0, cnt0..cnt3=0 and d_ready=0 during reset.
